stack_alu_sequencer: RTL and testbench
======================================

Name: stack_alu_sequencer

Overview:
- Program sequencer for the stack-machine datapath; sits between instruction memory, the stack, and the stack ALU.
- Fetches instructions, executes PUSH/POP directly on the stack, and launches ALU ADD/SUB.
- Owns the stack port and grants it to the ALU only while an ALU operation is in flight.
- Tracks stack depth, latches ALU flags, and reports halt and error status.

Parameters:
- DATA_LEN, 8: operand and stack word width.
- PC_W, 6: instruction address width.
- STACK_DEPTH, 16: stack capacity in words, used for the full check.
- TIMEOUT, 32: ALU watchdog limit in cycles; used only with ALU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin execution at PC=0; ignored while busy
- imem_addr  out  PC_W  instruction address
- imem_data  in  4+DATA_LEN  instruction, read data valid 1 cycle after the address; {opcode[3:0], imm}
- alu_ctrl  out  4  ALU control bus
- alu_en  out  1  ALU enable
- alu_fin  in  1  ALU finish pulse
- alu_z, alu_s  in  1 each  ALU zero/sign flags
- alu_stk_push, alu_stk_pop  in  1 each  ALU stack strobes; may be z/x when idle
- alu_stk_din  in  DATA_LEN  ALU push data
- stk_push, stk_pop  out  1 each  stack strobes (muxed)
- stk_din  out  DATA_LEN  stack push data (muxed)
- stk_dout  in  DATA_LEN  stack top data
- busy, halted, err  out  1 each  status
- pop_data  out  DATA_LEN  last popped value
- pop_valid  out  1  one-cycle pulse when pop_data updates
- z_flag, s_flag  out  1 each  flags latched from the ALU

Behaviour:
- Reset (asynchronous, rstn=0):
  - state IDLE, PC=0, depth=0.
  - All outputs 0; alu_ctrl=4'b0000.
  - Reset mid-operation aborts immediately.
- Opcodes:
  - 0000 NOP.
  - 0001 PUSH imm.
  - 0010 POP.
  - 0110 ADD: alu_ctrl=0110.
  - 0111 SUB: alu_ctrl=0111; result = second-from-top minus top.
  - 1111 HALT.
  - Any other opcode → ERR.
- IDLE: start=1 → FETCH, busy=1, halted=0, err=0, PC=0.
- FETCH: drive imem_addr=PC → DECODE.
- DECODE: register the instruction, PC <= PC+1 (wraps mod 2^PC_W), then dispatch:
  - NOP → FETCH.
  - PUSH: depth==STACK_DEPTH → ERR, else PUSH_S.
  - POP: depth==0 → ERR, else POP_S.
  - ADD/SUB: depth<2 → ERR, else ALU_GO.
  - HALT → HALT_S.
- PUSH_S: stk_push=1, stk_din=imm → PUSH_D.
- PUSH_D: stk_push=0, depth+1 → FETCH.
- POP_S: stk_pop=1 → POP_RCV.
- POP_RCV: stk_pop=0 → POP_STR.
- POP_STR: pop_data<=stk_dout, pop_valid=1 for one cycle, depth-1 → FETCH.
- ALU_GO:
  - alu_en=1 and alu_ctrl=opcode for exactly 1 cycle → ALU_WAIT.
  - Stack grant to ALU starts in this cycle.
- ALU_WAIT:
  - alu_en=0, alu_ctrl=0000.
  - On alu_fin=1: z_flag<=alu_z, s_flag<=alu_s, depth-1, release grant → FETCH.
- Stack mux:
  - Granted (ALU_GO/ALU_WAIT): stk_push = (alu_stk_push===1), stk_pop = (alu_stk_pop===1), stk_din=alu_stk_din.
  - Otherwise the controller drives. Outputs are never z/x.
- alu_en and alu_ctrl are 0 outside ALU_GO, so the ALU never re-triggers.
- HALT_S: busy=0, halted=1. start=1 → FETCH with PC=0, depth kept.
- ERR: busy=0, err=1, PC held at the faulting instruction+1. start=1 clears err, restarts at PC=0, depth=0.
- start during busy: ignored.
- alu_fin outside ALU_WAIT: ignored.
- Latencies:
  - PUSH 4 cycles.
  - POP 5 cycles, pop_valid on cycle 5.
  - NOP 2 cycles.
  - ALU op 3 cycles + ALU time.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined: a cycle counter runs in ALU_WAIT. If TIMEOUT cycles pass without alu_fin:
  - → ERR.
  - Grant released.
  - Flags unchanged.
- Undefined: ALU_WAIT waits indefinitely.

Decomposition:
- Shared package holds:
  - opcode constants: OP_NOP, OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_HALT.
  - state encoding constants.
  - instruction field widths.
- Sub-module stack_port_mux: combinational grant mux with z/x-safe strobe conversion.
- FSM, PC and depth counter stay in the top module.

Test Plan:
- PUSH 5, PUSH 3, SUB, POP, HALT → pop_data=2, z_flag=0, s_flag=0, halted=1, depth 0.
- PUSH 3, PUSH 5, SUB, POP, HALT → pop_data=8'hFE, s_flag=1; then PUSH 4, PUSH 4, SUB → z_flag=1.
- Error cases:
  - POP on empty stack → err=1, no stk_pop pulse.
  - STACK_DEPTH=4 and 5 PUSHes → err on 5th, exactly 4 push pulses.
  - ADD with depth 1 → err.
- Opcode 0101 → err=1. start during busy → no restart. start after err → clean run from PC=0.
- rstn low during ALU_WAIT → all outputs 0 in the same cycle, state IDLE, no stk strobes afterwards.
- With ALU_TIMEOUT_EN, TIMEOUT=32, alu_fin tied 0 → err rises exactly 32 cycles after entering ALU_WAIT. Without the macro → busy stays 1.

Source files
------------

// File: rtl/stack_alu_sequencer_pkg.sv
// rtl/stack_alu_sequencer_pkg.sv - shared constants and types for the stack ALU sequencer
//
// Purpose: opcode encodings, FSM state encoding and instruction field widths
//          shared by the sequencer top and its stack port mux.
// Ports:   none (package).

package stack_alu_sequencer_pkg;

   // Instruction layout is {opcode[OPC_W-1:0], imm[DATA_LEN-1:0]}
   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
   localparam logic [OPC_W-1:0] OP_PUSH = 4'b0001;
   localparam logic [OPC_W-1:0] OP_POP  = 4'b0010;
   localparam logic [OPC_W-1:0] OP_ADD  = 4'b0110;
   localparam logic [OPC_W-1:0] OP_SUB  = 4'b0111;
   localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

   // ALU control value driven whenever no operation is being launched
   localparam logic [3:0] ALU_CTRL_IDLE = 4'b0000;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_PUSH_S   = 4'd3,
      S_PUSH_D   = 4'd4,
      S_POP_S    = 4'd5,
      S_POP_RCV  = 4'd6,
      S_POP_STR  = 4'd7,
      S_ALU_GO   = 4'd8,
      S_ALU_WAIT = 4'd9,
      S_HALT     = 4'd10,
      S_ERR      = 4'd11
   } state_t;

   // Total instruction width for a given immediate width
   function automatic int instr_width(input int data_len);
      return OPC_W + data_len;
   endfunction

endpackage

// File: rtl/stack_alu_sequencer_stack_port_mux.sv
// rtl/stack_alu_sequencer_stack_port_mux.sv - stack port grant mux between sequencer and ALU
//
// Purpose: routes either the sequencer's own stack strobes/data or the ALU's
//          onto the shared stack port. ALU strobes are only honoured when they
//          are a definite 1, so a floating or unknown ALU bus never reaches the stack.
// Ports:
//   i_grant                  1 = ALU owns the stack port
//   i_ctl_push/i_ctl_pop     sequencer stack strobes
//   i_ctl_din  [DATA_LEN]    sequencer push data
//   i_alu_push/i_alu_pop     ALU stack strobes (may be z/x when idle)
//   i_alu_din  [DATA_LEN]    ALU push data
//   o_push/o_pop             stack strobes to the stack
//   o_din      [DATA_LEN]    stack push data

module stack_port_mux #(
   parameter int DATA_LEN = 8
) (
   input  logic                i_grant,
   input  logic                i_ctl_push,
   input  logic                i_ctl_pop,
   input  logic [DATA_LEN-1:0] i_ctl_din,
   input  logic                i_alu_push,
   input  logic                i_alu_pop,
   input  logic [DATA_LEN-1:0] i_alu_din,
   output logic                o_push,
   output logic                o_pop,
   output logic [DATA_LEN-1:0] o_din
);

   logic w_alu_push;
   logic w_alu_pop;

   // Case-equality turns z/x into a clean 0
   assign w_alu_push = (i_alu_push === 1'b1);
   assign w_alu_pop  = (i_alu_pop === 1'b1);

   always_comb begin
      o_push = i_ctl_push;
      o_pop  = i_ctl_pop;
      o_din  = i_ctl_din;
      if (i_grant) begin
         o_push = w_alu_push;
         o_pop  = w_alu_pop;
         // Data only passed while the ALU is actually pushing, so an idle ALU bus stays off the port
         o_din  = w_alu_push ? i_alu_din : '0;
      end
   end

endmodule

// File: rtl/stack_alu_sequencer.sv
// rtl/stack_alu_sequencer.sv - program sequencer for the stack-machine datapath
//
// Purpose: fetches {opcode, imm} instructions, executes PUSH/POP on the stack,
//          launches ALU ADD/SUB with the stack port granted to the ALU while the
//          operation is in flight, tracks stack depth and latches ALU flags.
// Build option: define ALU_TIMEOUT_EN to add an ALU watchdog of TIMEOUT cycles
//          in ALU_WAIT (expiry -> error state, flags untouched).
// Ports:
//   clk, rstn                clock, asynchronous active-low reset
//   start                    begin execution at PC=0 (ignored while busy)
//   imem_addr/imem_data      instruction memory, data valid one cycle after address
//   alu_ctrl/alu_en          ALU launch (only during ALU_GO)
//   alu_fin/alu_z/alu_s      ALU completion pulse and flags
//   alu_stk_push/pop/din     ALU stack requests, honoured only while granted
//   stk_push/stk_pop/stk_din stack port (muxed)
//   stk_dout                 stack read data
//   busy/halted/err          status
//   pop_data/pop_valid       last popped value and its update pulse
//   z_flag/s_flag            latched ALU flags

module stack_alu_sequencer
   import stack_alu_sequencer_pkg::*;
#(
   parameter int DATA_LEN    = 8,
   parameter int PC_W        = 6,
   parameter int STACK_DEPTH = 16,
   parameter int TIMEOUT     = 32
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               start,
   output logic [PC_W-1:0]                    imem_addr,
   input  logic [instr_width(DATA_LEN)-1:0]   imem_data,
   output logic [3:0]                         alu_ctrl,
   output logic                               alu_en,
   input  logic                               alu_fin,
   input  logic                               alu_z,
   input  logic                               alu_s,
   input  logic                               alu_stk_push,
   input  logic                               alu_stk_pop,
   input  logic [DATA_LEN-1:0]                alu_stk_din,
   output logic                               stk_push,
   output logic                               stk_pop,
   output logic [DATA_LEN-1:0]                stk_din,
   input  logic [DATA_LEN-1:0]                stk_dout,
   output logic                               busy,
   output logic                               halted,
   output logic                               err,
   output logic [DATA_LEN-1:0]                pop_data,
   output logic                               pop_valid,
   output logic                               z_flag,
   output logic                               s_flag
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   state_t              r_state;
   state_t              w_next;
   logic [PC_W-1:0]     r_pc;
   logic [DEPTH_W-1:0]  r_depth;
   logic [OPC_W-1:0]    r_op;
   logic [DATA_LEN-1:0] r_imm;
   logic [DATA_LEN-1:0] r_pop_data;
   logic                r_z;
   logic                r_s;

   logic [OPC_W-1:0]    w_opc;
   logic [DATA_LEN-1:0] w_imm;
   logic                w_full;
   logic                w_empty;
   logic                w_lt2;
   logic                w_grant;
   logic                w_ctl_push;
   logic                w_ctl_pop;
   logic                w_to_expired;

   assign w_opc   = imem_data[OPC_W+DATA_LEN-1 -: OPC_W];
   assign w_imm   = imem_data[DATA_LEN-1:0];
   assign w_full  = (r_depth == DEPTH_W'(STACK_DEPTH));
   assign w_empty = (r_depth == '0);
   assign w_lt2   = (r_depth < DEPTH_W'(2));

   // ALU watchdog
`ifdef ALU_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_to_cnt <= '0;
      end else if (r_state == S_ALU_WAIT) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
         r_to_cnt <= '0;
      end
   end

   // Counter holds the number of ALU_WAIT cycles already spent
   assign w_to_expired = (r_state == S_ALU_WAIT) && (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
   // No watchdog in this build; TIMEOUT is never negative, so this stays low
   assign w_to_expired = (TIMEOUT < 0);
`endif

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and controller-side stack strobes
   always_comb begin
      w_next     = r_state;
      w_ctl_push = 1'b0;
      w_ctl_pop  = 1'b0;
      case (r_state)
         S_IDLE:     if (start) w_next = S_FETCH;
         S_FETCH:    w_next = S_DECODE;
         S_DECODE: begin
            case (w_opc)
               OP_NOP:  w_next = S_FETCH;
               OP_PUSH: w_next = w_full  ? S_ERR : S_PUSH_S;
               OP_POP:  w_next = w_empty ? S_ERR : S_POP_S;
               OP_ADD,
               OP_SUB:  w_next = w_lt2   ? S_ERR : S_ALU_GO;
               OP_HALT: w_next = S_HALT;
               default: w_next = S_ERR;
            endcase
         end
         S_PUSH_S: begin
            w_ctl_push = 1'b1;
            w_next     = S_PUSH_D;
         end
         S_PUSH_D:   w_next = S_FETCH;
         S_POP_S: begin
            w_ctl_pop = 1'b1;
            w_next    = S_POP_RCV;
         end
         S_POP_RCV:  w_next = S_POP_STR;
         S_POP_STR:  w_next = S_FETCH;
         S_ALU_GO:   w_next = S_ALU_WAIT;
         S_ALU_WAIT: begin
            // A finish in the expiry cycle still counts as a completed operation
            if (alu_fin)           w_next = S_FETCH;
            else if (w_to_expired) w_next = S_ERR;
         end
         S_HALT,
         S_ERR:      if (start) w_next = S_FETCH;
         default:    w_next = S_IDLE;
      endcase
   end

   // PC, depth, instruction, pop data and flag registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc       <= '0;
         r_depth    <= '0;
         r_op       <= OP_NOP;
         r_imm      <= '0;
         r_pop_data <= '0;
         r_z        <= 1'b0;
         r_s        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE,
            S_HALT: if (start) r_pc <= '0;
            S_ERR: begin
               if (start) begin
                  r_pc    <= '0;
                  r_depth <= '0;
               end
            end
            S_DECODE: begin
               r_op  <= w_opc;
               r_imm <= w_imm;
               r_pc  <= r_pc + 1'b1;
            end
            S_PUSH_D:  r_depth <= r_depth + 1'b1;
            S_POP_STR: begin
               r_pop_data <= stk_dout;
               r_depth    <= r_depth - 1'b1;
            end
            S_ALU_WAIT: begin
               // Two operands popped, one result pushed: net depth -1
               if (alu_fin) begin
                  r_z     <= alu_z;
                  r_s     <= alu_s;
                  r_depth <= r_depth - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_grant = (r_state == S_ALU_GO) || (r_state == S_ALU_WAIT);

   stack_port_mux #(
      .DATA_LEN (DATA_LEN)
   ) u_stack_port_mux (
      .i_grant    (w_grant),
      .i_ctl_push (w_ctl_push),
      .i_ctl_pop  (w_ctl_pop),
      .i_ctl_din  (r_imm),
      .i_alu_push (alu_stk_push),
      .i_alu_pop  (alu_stk_pop),
      .i_alu_din  (alu_stk_din),
      .o_push     (stk_push),
      .o_pop      (stk_pop),
      .o_din      (stk_din)
   );

   assign imem_addr = r_pc;
   assign alu_en    = (r_state == S_ALU_GO);
   assign alu_ctrl  = (r_state == S_ALU_GO) ? r_op : ALU_CTRL_IDLE;
   assign busy      = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR);
   assign halted    = (r_state == S_HALT);
   assign err       = (r_state == S_ERR);
   assign pop_valid = (r_state == S_POP_STR);
   // The new value is visible in the same cycle as pop_valid, then held
   assign pop_data  = (r_state == S_POP_STR) ? stk_dout : r_pop_data;
   assign z_flag    = r_z;
   assign s_flag    = r_s;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb/tb_stack_alu_sequencer.sv - directed scoreboard bench for stack_alu_sequencer

module tb_stack_alu_sequencer;

   localparam logic [3:0] NOP = 4'b0000, PUSH = 4'b0001, POP = 4'b0010;
   localparam logic [3:0] ADD = 4'b0110, SUB = 4'b0111, HALT = 4'b1111, BAD = 4'b0101;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  imem_addr;
   logic [11:0] imem_q;
   logic [3:0]  alu_ctrl;
   logic        alu_en;
   logic        alu_fin, alu_z, alu_s, alu_stk_push, alu_stk_pop;
   logic [7:0]  alu_stk_din;
   logic        stk_push, stk_pop;
   logic [7:0]  stk_din;
   logic [7:0]  stk_dout_r;
   logic        busy, halted, err, pop_valid, z_flag, s_flag;
   logic [7:0]  pop_data;

   int total = 0;
   int bad = 0;

   logic [11:0] imem [0:63];
   logic [7:0]  stk_mem [0:15];
   int          sp = 0;
   int          push_cnt = 0;
   int          pop_cnt = 0;
   logic        stk_clr = 1'b0;
   logic        alu_mute = 1'b0;
   int          alu_ph;
   logic [7:0]  alu_res;
   logic [7:0]  exp_q [$];

   always #5 clk = ~clk;

   stack_alu_sequencer #(
      .DATA_LEN(8), .PC_W(6), .STACK_DEPTH(4), .TIMEOUT(32)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_q),
      .alu_ctrl(alu_ctrl), .alu_en(alu_en), .alu_fin(alu_fin),
      .alu_z(alu_z), .alu_s(alu_s),
      .alu_stk_push(alu_stk_push), .alu_stk_pop(alu_stk_pop), .alu_stk_din(alu_stk_din),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout_r),
      .busy(busy), .halted(halted), .err(err),
      .pop_data(pop_data), .pop_valid(pop_valid),
      .z_flag(z_flag), .s_flag(s_flag)
   );

   // Instruction memory: synchronous read, one cycle latency
   always @(posedge clk) imem_q <= imem[imem_addr];

   // Stack model: pop returns the old top on a registered read port
   always @(posedge clk) begin
      if (stk_push) push_cnt <= push_cnt + 1;
      if (stk_pop)  pop_cnt  <= pop_cnt + 1;
      if (stk_clr) begin
         sp <= 0;
      end else if (stk_push && sp < 16) begin
         stk_mem[sp] <= stk_din;
         sp          <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         stk_dout_r <= stk_mem[sp-1];
         sp         <= sp - 1;
      end
   end

   // ALU model: pop, pop, push result, finish pulse; strobes float when idle
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         alu_ph       <= 0;
         alu_stk_push <= 1'bx;
         alu_stk_pop  <= 1'bx;
         alu_stk_din  <= 8'hxx;
         alu_fin      <= 1'b0;
         alu_z        <= 1'b0;
         alu_s        <= 1'b0;
         alu_res      <= 8'h00;
      end else begin
         case (alu_ph)
            0: if (alu_en && !alu_mute) begin
                  if (sp >= 2)
                     alu_res <= (alu_ctrl == ADD) ? stk_mem[sp-2] + stk_mem[sp-1]
                                                  : stk_mem[sp-2] - stk_mem[sp-1];
                  alu_stk_pop  <= 1'b1;
                  alu_stk_push <= 1'b0;
                  alu_ph       <= 1;
               end
            1: alu_ph <= 2;
            2: begin
               alu_stk_pop  <= 1'b0;
               alu_stk_push <= 1'b1;
               alu_stk_din  <= alu_res;
               alu_ph       <= 3;
            end
            3: begin
               alu_stk_push <= 1'bx;
               alu_stk_pop  <= 1'bx;
               alu_fin      <= 1'b1;
               alu_z        <= (alu_res == 8'h00);
               alu_s        <= alu_res[7];
               alu_ph       <= 4;
            end
            default: begin
               alu_fin <= 1'b0;
               alu_ph  <= 0;
            end
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input int a, input logic [3:0] op, input logic [7:0] imm);
      imem[a] = {op, imm};
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear_stack();
      stk_clr = 1'b1;
      @(negedge clk);
      stk_clr = 1'b0;
   endtask

   // Runs until the sequencer leaves busy; checks each pop against the scoreboard.
   // poke >= 0 asserts start during that busy cycle.
   task automatic run(input int max, input int poke, output int cyc);
      cyc = 0;
      while (busy && cyc < max) begin
         if (pop_valid) begin
            if (exp_q.size() > 0) check("pop_data", pop_data, exp_q.pop_front());
            else check("pop_unexpected", pop_valid, 1'b0);
         end
         start = (cyc == poke);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (busy) check("run_timeout", busy, 1'b0);
      check("pops_missing", exp_q.size(), 0);
   endtask

   task automatic wait_alu_en();
      for (int i = 0; i < 60; i++) begin
         if (alu_en) break;
         @(negedge clk);
      end
      check("alu_en_seen", alu_en, 1'b1);
   endtask

   initial begin
      int cyc;
      int p0;
      int q0;
      for (int i = 0; i < 64; i++) imem[i] = {HALT, 8'h00};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_pop_valid", pop_valid, 1'b0);
      check("rst_pop_data", pop_data, 8'h00);
      check("rst_flags", {z_flag, s_flag}, 2'b00);
      check("rst_alu", {alu_en, alu_ctrl}, 5'b0);
      check("rst_stk", {stk_push, stk_pop, stk_din}, 10'b0);
      check("rst_imem_addr", imem_addr, 6'd0);
      rstn = 1'b1;
      @(negedge clk);

      // 5 - 3 = 2
      put(0, PUSH, 8'd5); put(1, PUSH, 8'd3); put(2, SUB, 8'd0); put(3, POP, 8'd0); put(4, HALT, 8'd0);
      exp_q.push_back(8'd2);
      pulse_start();
      run(200, -1, cyc);
      check("t1_cycles", cyc, 22);
      check("t1_halted", halted, 1'b1);
      check("t1_err", err, 1'b0);
      check("t1_pop_data", pop_data, 8'd2);
      check("t1_flags", {z_flag, s_flag}, 2'b00);
      check("t1_stack_empty", sp, 0);
      check("t1_pc", imem_addr, 6'd5);

      // 3 - 5 = FE, sign set
      put(0, PUSH, 8'd3); put(1, PUSH, 8'd5);
      exp_q.push_back(8'hFE);
      pulse_start();
      run(200, -1, cyc);
      check("t2_pop_data", pop_data, 8'hFE);
      check("t2_flags", {z_flag, s_flag}, 2'b01);

      // 4 - 4 = 0, zero set; result stays on the stack
      put(0, PUSH, 8'd4); put(1, PUSH, 8'd4); put(2, SUB, 8'd0); put(3, HALT, 8'd0);
      pulse_start();
      run(200, -1, cyc);
      check("t2b_flags", {z_flag, s_flag}, 2'b10);
      check("t2b_halted", halted, 1'b1);
      check("t2b_stack", sp, 1);

      // ALU never finishes (depth kept at 1 from HALT, push one more)
      alu_mute = 1'b1;
      put(0, PUSH, 8'd2); put(1, SUB, 8'd0); put(2, HALT, 8'd0);
      pulse_start();
      wait_alu_en();
`ifdef ALU_TIMEOUT_EN
      cyc = 0;
      while (!err && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("to_cycles", cyc, 33);
      check("to_busy", busy, 1'b0);
      check("to_flags_kept", {z_flag, s_flag}, 2'b10);
      check("to_grant_released", {stk_push, stk_pop}, 2'b00);
`else
      repeat (4) @(negedge clk);
      check("wait_grant_xsafe", {stk_push, stk_pop}, 2'b00);
      repeat (56) @(negedge clk);
      check("wait_busy", busy, 1'b1);
      check("wait_err", err, 1'b0);
`endif
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      alu_mute = 1'b0;
      clear_stack();

      // Illegal opcode from IDLE
      put(0, BAD, 8'd0);
      pulse_start();
      run(50, -1, cyc);
      check("bad_err", err, 1'b1);
      check("bad_halted", halted, 1'b0);
      check("bad_pc", imem_addr, 6'd1);
      check("bad_cycles", cyc, 2);

      // POP on empty stack
      put(0, POP, 8'd0); put(1, HALT, 8'd0);
      p0 = pop_cnt;
      pulse_start();
      run(50, -1, cyc);
      check("empty_err", err, 1'b1);
      check("empty_no_pop", pop_cnt - p0, 0);

      // Overflow at depth 4
      for (int i = 0; i < 5; i++) put(i, PUSH, 8'(i + 1));
      put(5, HALT, 8'd0);
      p0 = push_cnt;
      pulse_start();
      run(100, -1, cyc);
      check("full_err", err, 1'b1);
      check("full_pushes", push_cnt - p0, 4);
      check("full_pc", imem_addr, 6'd5);
      check("full_cycles", cyc, 18);

      // ADD with only one operand
      clear_stack();
      put(0, PUSH, 8'd7); put(1, ADD, 8'd0); put(2, HALT, 8'd0);
      p0 = pop_cnt;
      pulse_start();
      run(50, -1, cyc);
      check("add1_err", err, 1'b1);
      check("add1_pc", imem_addr, 6'd2);
      check("add1_no_alu", pop_cnt - p0, 0);

      // Clean restart after error, with start poked while busy
      clear_stack();
      put(0, PUSH, 8'd5); put(1, PUSH, 8'd3); put(2, SUB, 8'd0); put(3, POP, 8'd0); put(4, HALT, 8'd0);
      exp_q.push_back(8'd2);
      pulse_start();
      check("restart_err_clear", err, 1'b0);
      run(200, 3, cyc);
      check("restart_cycles", cyc, 22);
      check("restart_halted", halted, 1'b1);
      check("restart_pop", pop_data, 8'd2);

      // Reset while the ALU holds the stack port
      clear_stack();
      put(0, PUSH, 8'd1); put(1, PUSH, 8'd2); put(2, ADD, 8'd0); put(3, HALT, 8'd0);
      pulse_start();
      wait_alu_en();
      check("go_alu_ctrl", alu_ctrl, ADD);
      @(negedge clk);
      check("wait_alu_ctrl", {alu_en, alu_ctrl}, 5'b0);
      check("wait_grant_pop", stk_pop, 1'b1);
      #2 rstn = 1'b0;
      #1;
      check("arst_status", {busy, halted, err, pop_valid}, 4'b0);
      check("arst_stk", {stk_push, stk_pop}, 2'b00);
      check("arst_alu", {alu_en, alu_ctrl}, 5'b0);
      check("arst_flags_pc", {z_flag, s_flag, imem_addr}, 8'b0);
      @(negedge clk);
      rstn = 1'b1;
      p0 = push_cnt;
      q0 = pop_cnt;
      repeat (10) @(negedge clk);
      check("arst_no_strobes", (push_cnt - p0) + (pop_cnt - q0), 0);
      check("arst_idle", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
